softmax_norm: RTL and testbench

SOFTMAX_NORM -- requirements
Module: softmax_norm

---
 rtl/softmax_norm.sv | 127 ++++++++++++
 tb/tb_softmax_norm.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/softmax_norm.sv
// Buffers one row of exponents, then emits each element divided by the row sum as a Q0.8 probability.
// Row close to first out_valid is 10 cycles; each further element is 10 cycles; credits return after the row drains.
module softmax_norm #(
   parameter int DEPTH = 8,
   parameter int SW    = 9 + $clog2(DEPTH)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ex_valid,
   input  logic [8:0] ex_data,
   input  logic       ex_last,
   output logic       credit_ret,
   output logic       out_valid,
   output logic [7:0] out_data,
   output logic       out_last,
   input  logic       out_ready,
   output logic       err_ovf
);

   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;
   localparam int DW = SW + 8;

   typedef enum logic [1:0] {ACCUM, DIV, OUT, CRED} state_t;

   state_t          state, state_nx;
   logic [8:0]      buffer [DEPTH];
   logic [SW-1:0]   sum;
   logic [CW-1:0]   count;
   logic [IW-1:0]   idx;
   logic [3:0]      step;
   logic [DW-1:0]   rem, dvs, op_rem, op_dvs, rem_nx;
   logic [8:0]      quo, quo_nx;
   logic            take, row_close, div_done, last_elem;

   assign take      = (state == ACCUM) && ex_valid;
   assign row_close = take && (ex_last || (count == CW'(DEPTH - 1)));
   assign div_done  = (state == DIV) && (step == 4'd8);
   // idx doubles as the credit counter while in CRED
   assign last_elem = ({1'b0, idx} == (count - CW'(1)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ACCUM;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      out_valid  = 1'b0;
      credit_ret = 1'b0;
      case (state)
         ACCUM: if (row_close) state_nx = DIV;
         DIV:   if (step == 4'd8) state_nx = OUT;
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = last_elem ? CRED : DIV;
         end
         CRED: begin
            credit_ret = 1'b1;
            if (last_elem) state_nx = ACCUM;
         end
         default: state_nx = ACCUM;
      endcase
   end

   // First divide step loads operands straight from the buffer so a row closed
   // by its very first element still sees the freshly written value.
   always_comb begin
      op_rem = (step == 4'd0) ? DW'({buffer[idx], 8'h00}) : rem;
      op_dvs = (step == 4'd0) ? DW'({sum, 8'h00}) : dvs;
      if (op_rem >= op_dvs) begin
         rem_nx = op_rem - op_dvs;
         quo_nx = {quo[7:0], 1'b1};
      end else begin
         rem_nx = op_rem;
         quo_nx = {quo[7:0], 1'b0};
      end
   end

   always_ff @(posedge clk) begin
      if (take) buffer[count[IW-1:0]] <= ex_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum      <= '0;
         count    <= '0;
         idx      <= '0;
         step     <= '0;
         rem      <= '0;
         dvs      <= '0;
         quo      <= '0;
         out_data <= '0;
         out_last <= 1'b0;
         err_ovf  <= 1'b0;
      end else begin
         if (ex_valid && (state != ACCUM)) err_ovf <= 1'b1;
         if (take) begin
            sum   <= sum + SW'(ex_data);
            count <= count + CW'(1);
         end
         if (row_close) idx <= '0;
         if (state == DIV) begin
            rem  <= rem_nx;
            dvs  <= op_dvs >> 1;
            quo  <= quo_nx;
            step <= div_done ? 4'd0 : step + 4'd1;
            if (div_done) begin
               // A zero sum means every element is zero; the raw quotient would read all ones.
               out_data <= (sum == '0) ? 8'h00 : (quo_nx[8] ? 8'hFF : quo_nx[7:0]);
               out_last <= last_elem;
            end
         end
         if ((state == OUT) && out_ready) idx <= last_elem ? '0 : idx + IW'(1);
         if (state == CRED) begin
            if (last_elem) begin
               idx   <= '0;
               sum   <= '0;
               count <= '0;
            end else begin
               idx <= idx + IW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_softmax_norm.sv
// Directed bench for softmax_norm: row normalisation, saturation, auto-close, backpressure, reset.
module tb_softmax_norm;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ex_valid = 1'b0;
   logic [8:0] ex_data = '0;
   logic       ex_last = 1'b0;
   logic       out_ready = 1'b1;
   logic       credit_ret, out_valid, out_last, err_ovf;
   logic [7:0] out_data;

   int checks = 0;
   int failures = 0;
   int cred_cnt = 0;
   int hs_cnt = 0;

   logic [7:0] got_d [16];
   logic       got_l [16];
   int         got_gap [16];
   bit         timed_out;

   softmax_norm #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_data(ex_data), .ex_last(ex_last),
      .credit_ret(credit_ret), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
      .out_ready(out_ready), .err_ovf(err_ovf)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && credit_ret) cred_cnt++;
      if (rst_n && out_valid && out_ready) hs_cnt++;
   end

   task automatic send(input logic [8:0] d, input logic l);
      ex_valid = 1'b1; ex_data = d; ex_last = l;
      @(posedge clk); #1;
      ex_valid = 1'b0; ex_last = 1'b0;
   endtask

   // Records n outputs with out_ready high; got_gap is cycles from input/handshake to out_valid.
   task automatic collect(input int n);
      int wc;
      timed_out = 0;
      wc = 1;
      for (int i = 0; i < n; i++) begin
         while (!out_valid && wc < 40) begin @(posedge clk); #1; wc++; end
         if (!out_valid) begin timed_out = 1; break; end
         got_d[i] = out_data; got_l[i] = out_last; got_gap[i] = wc;
         @(posedge clk); #1;
         wc = 1;
      end
   endtask

   task automatic settle();
      repeat (DEPTH + 4) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
      checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
      checks++; if (credit_ret !== 1'b0) begin failures++; $display("FAIL reset_credit got=%b exp=0", credit_ret); end
      checks++; if (err_ovf !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_ovf); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int c0;
      c0 = cred_cnt;
      send(9'd256, 1'b0);
      send(9'd256, 1'b1);
      collect(2);
      settle();
      checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL basic_timeout got=%b exp=0", timed_out); end
      for (int i = 0; i < 2; i++) begin
         checks++; if (got_d[i] !== 8'd128) begin failures++; $display("FAIL basic_data[%0d] got=%0d exp=128", i, got_d[i]); end
         checks++; if (got_l[i] !== (i == 1)) begin failures++; $display("FAIL basic_last[%0d] got=%b exp=%b", i, got_l[i], (i == 1)); end
         checks++; if (got_gap[i] !== 10) begin failures++; $display("FAIL basic_latency[%0d] got=%0d exp=10", i, got_gap[i]); end
      end
      checks++; if (cred_cnt - c0 !== 2) begin failures++; $display("FAIL basic_credits got=%0d exp=2", cred_cnt - c0); end
      checks++; if (err_ovf !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", err_ovf); end
   endtask

   task automatic test_saturate();
      int c0;
      c0 = cred_cnt;
      send(9'd256, 1'b1);
      collect(1);
      settle();
      checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL sat_timeout got=%b exp=0", timed_out); end
      checks++; if (got_d[0] !== 8'd255) begin failures++; $display("FAIL sat_data got=%0d exp=255", got_d[0]); end
      checks++; if (got_l[0] !== 1'b1) begin failures++; $display("FAIL sat_last got=%b exp=1", got_l[0]); end
      checks++; if (cred_cnt - c0 !== 1) begin failures++; $display("FAIL sat_credits got=%0d exp=1", cred_cnt - c0); end
   endtask

   task automatic test_zero_sum();
      int c0;
      c0 = cred_cnt;
      send(9'd0, 1'b0);
      send(9'd0, 1'b1);
      collect(2);
      settle();
      checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL zero_timeout got=%b exp=0", timed_out); end
      for (int i = 0; i < 2; i++) begin
         checks++; if (got_d[i] !== 8'd0) begin failures++; $display("FAIL zero_data[%0d] got=%0d exp=0", i, got_d[i]); end
         checks++; if (got_l[i] !== (i == 1)) begin failures++; $display("FAIL zero_last[%0d] got=%b exp=%b", i, got_l[i], (i == 1)); end
      end
      checks++; if (cred_cnt - c0 !== 2) begin failures++; $display("FAIL zero_credits got=%0d exp=2", cred_cnt - c0); end
      checks++; if (err_ovf !== 1'b0) begin failures++; $display("FAIL zero_err got=%b exp=0", err_ovf); end
   endtask

   task automatic test_autoclose();
      int c0;
      c0 = cred_cnt;
      for (int i = 0; i < DEPTH; i++) send(9'd64, 1'b0);
      collect(DEPTH);
      settle();
      checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL auto_timeout got=%b exp=0", timed_out); end
      for (int i = 0; i < DEPTH; i++) begin
         checks++; if (got_d[i] !== 8'd32) begin failures++; $display("FAIL auto_data[%0d] got=%0d exp=32", i, got_d[i]); end
         checks++; if (got_l[i] !== (i == DEPTH - 1)) begin failures++; $display("FAIL auto_last[%0d] got=%b exp=%b", i, got_l[i], (i == DEPTH - 1)); end
         checks++; if (got_gap[i] !== 10) begin failures++; $display("FAIL auto_gap[%0d] got=%0d exp=10", i, got_gap[i]); end
      end
      checks++; if (cred_cnt - c0 !== DEPTH) begin failures++; $display("FAIL auto_credits got=%0d exp=%0d", cred_cnt - c0, DEPTH); end
   endtask

   task automatic test_backpressure();
      int c0, h0, wc;
      c0 = cred_cnt; h0 = hs_cnt;
      out_ready = 1'b0;
      send(9'd256, 1'b0);
      send(9'd256, 1'b1);
      wc = 0;
      while (!out_valid && wc < 40) begin @(posedge clk); #1; wc++; end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_first_valid got=%b exp=1", out_valid); end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid[%0d] got=%b exp=1", i, out_valid); end
         checks++; if (out_data !== 8'd128) begin failures++; $display("FAIL bp_hold_data[%0d] got=%0d exp=128", i, out_data); end
         checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL bp_hold_last[%0d] got=%b exp=0", i, out_last); end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_after_hs_valid got=%b exp=0", out_valid); end
      send(9'd5, 1'b1);
      checks++; if (err_ovf !== 1'b1) begin failures++; $display("FAIL bp_err_set got=%b exp=1", err_ovf); end
      wc = 0;
      while (!out_valid && wc < 40) begin @(posedge clk); #1; wc++; end
      checks++; if (out_data !== 8'd128) begin failures++; $display("FAIL bp_second_data got=%0d exp=128", out_data); end
      checks++; if (out_last !== 1'b1) begin failures++; $display("FAIL bp_second_last got=%b exp=1", out_last); end
      @(posedge clk); #1;
      settle();
      checks++; if (hs_cnt - h0 !== 2) begin failures++; $display("FAIL bp_handshakes got=%0d exp=2", hs_cnt - h0); end
      checks++; if (cred_cnt - c0 !== 2) begin failures++; $display("FAIL bp_credits got=%0d exp=2", cred_cnt - c0); end
      checks++; if (err_ovf !== 1'b1) begin failures++; $display("FAIL bp_err_sticky got=%b exp=1", err_ovf); end
   endtask

   task automatic test_reset_mid_row();
      int c0;
      send(9'd100, 1'b0);
      send(9'd300, 1'b1);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL mid_out_data got=%0d exp=0", out_data); end
      checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL mid_out_last got=%b exp=0", out_last); end
      checks++; if (credit_ret !== 1'b0) begin failures++; $display("FAIL mid_credit got=%b exp=0", credit_ret); end
      checks++; if (err_ovf !== 1'b0) begin failures++; $display("FAIL mid_err got=%b exp=0", err_ovf); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      c0 = cred_cnt;
      repeat (15) @(posedge clk);
      #1;
      checks++; if (cred_cnt - c0 !== 0) begin failures++; $display("FAIL mid_no_credits got=%0d exp=0", cred_cnt - c0); end
      send(9'd128, 1'b1);
      collect(1);
      settle();
      checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL mid_next_timeout got=%b exp=0", timed_out); end
      checks++; if (got_d[0] !== 8'd255) begin failures++; $display("FAIL mid_next_data got=%0d exp=255", got_d[0]); end
      checks++; if (got_l[0] !== 1'b1) begin failures++; $display("FAIL mid_next_last got=%b exp=1", got_l[0]); end
      checks++; if (cred_cnt - c0 !== 1) begin failures++; $display("FAIL mid_next_credits got=%0d exp=1", cred_cnt - c0); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturate();
      test_zero_sum();
      test_autoclose();
      test_backpressure();
      test_reset_mid_row();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
